// File: rtl/led_sequence_ctrl.sv
// LED up/down counting sequencer: prescaled step tick, 0..15 up phase, slower down phase.
// Optional SEQ_PAUSE_EN build adds a pause input that freezes the running sequence.
module led_sequence_ctrl #(
    parameter int unsigned TICK_DIV = 1500000,
    parameter int unsigned DOWN_DIV = 4,
    parameter int unsigned LOOPS    = 1
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic       go,
    input  logic       stop,
    input  logic       pause,
    output logic [3:0] led,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(DOWN_DIV + 1);
    localparam int unsigned LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [PW-1:0] PresMax  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] StepLast = SW'(DOWN_DIV - 1);
    localparam logic [LW-1:0] LoopLast = LW'((LOOPS == 0) ? 0 : LOOPS - 1);

    typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] step_q, step_d;
    logic [LW-1:0] loop_q, loop_d;
    logic [3:0]    led_q, led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick;
    logic          hold;

`ifdef SEQ_PAUSE_EN
    assign hold = pause && (state_q != StIdle);
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign hold = 1'b0;
`endif

    assign tick = (presc_q == PresMax);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        step_d  = step_q;
        loop_d  = loop_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = StIdle;
            presc_d = '0;
            step_d  = '0;
            led_d   = 4'd0;
            busy_d  = 1'b0;
        end else if (!hold) begin
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        state_d = StUp;
                        presc_d = '0;
                        loop_d  = '0;
                        led_d   = 4'd0;
                        busy_d  = 1'b1;
                    end
                end
                StUp: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (led_q != 4'd15) begin
                            led_d = led_q + 4'd1;
                        end else begin
                            state_d = StDown;
                            step_d  = '0;
                        end
                    end
                end
                StDown: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (step_q == StepLast) begin
                            step_d = '0;
                            if (led_q != 4'd0) begin
                                led_d = led_q - 4'd1;
                            end else if ((LOOPS != 0) && (loop_q == LoopLast)) begin
                                state_d = StIdle;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                // Free-running mode only needs the counter to stop wrapping.
                                loop_d  = (loop_q == '1) ? loop_q : loop_q + 1'b1;
                                state_d = StUp;
                            end
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_q <= StIdle;
            presc_q <= '0;
            step_q  <= '0;
            loop_q  <= '0;
            led_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            loop_q  <= loop_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Directed bench for led_sequence_ctrl: two instances (LOOPS=1, LOOPS=2) on shared stimulus.
// Edge n means the n-th rising clock edge after reset release; outputs sampled 1 time unit later.
module tb_led_sequence_ctrl;

    logic       clk = 1'b0;
    logic       rst_btn = 1'b0;
    logic       go = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] led1, led2;
    logic       busy1, busy2, done1, done2;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int go_at[4];
    int stop_at[2];
    int p_lo = -1;
    int p_hi = -1;

    typedef struct {
        int         e;
        logic [5:0] x1;
        logic [5:0] x2;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    led_sequence_ctrl #(.TICK_DIV(4), .DOWN_DIV(2), .LOOPS(1)) dut1 (
        .clk(clk), .rst_btn(rst_btn), .go(go), .stop(stop), .pause(pause),
        .led(led1), .busy(busy1), .done(done1)
    );

    led_sequence_ctrl #(.TICK_DIV(4), .DOWN_DIV(2), .LOOPS(2)) dut2 (
        .clk(clk), .rst_btn(rst_btn), .go(go), .stop(stop), .pause(pause),
        .led(led2), .busy(busy2), .done(done2)
    );

    function automatic logic [5:0] st(input int l, input int b, input int d);
        return {4'(l), 1'(b), 1'(d)};
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got led=%0d busy=%0b done=%0b, want led=%0d busy=%0b done=%0b",
                     name, edge_n, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic clear_sched();
        foreach (go_at[i]) go_at[i] = -1;
        foreach (stop_at[i]) stop_at[i] = -1;
        p_lo = -1;
        p_hi = -1;
    endtask

    task automatic drive_next();
        int nx = edge_n + 1;
        go = 1'b0;
        stop = 1'b0;
        foreach (go_at[i]) if (go_at[i] == nx) go = 1'b1;
        foreach (stop_at[i]) if (stop_at[i] == nx) stop = 1'b1;
        pause = (nx >= p_lo) && (nx <= p_hi);
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
            edge_n++;
            drive_next();
        end
    endtask

    task automatic do_reset();
        rst_btn = 1'b0;
        go = 1'b0;
        stop = 1'b0;
        pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset1", {led1, busy1, done1}, st(0, 0, 0));
        chk("reset2", {led2, busy2, done2}, st(0, 0, 0));
        rst_btn = 1'b1;
        edge_n = 0;
        drive_next();
    endtask

    initial begin
        logic seen;

        // Nominal run, go re-pulsed at edge 30 while busy
        tbl.push_back('{9,   st(0, 0, 0),  st(0, 0, 0)});
        tbl.push_back('{10,  st(0, 1, 0),  st(0, 1, 0)});
        tbl.push_back('{13,  st(0, 1, 0),  st(0, 1, 0)});
        tbl.push_back('{14,  st(1, 1, 0),  st(1, 1, 0)});
        tbl.push_back('{30,  st(5, 1, 0),  st(5, 1, 0)});
        tbl.push_back('{31,  st(5, 1, 0),  st(5, 1, 0)});
        tbl.push_back('{34,  st(6, 1, 0),  st(6, 1, 0)});
        tbl.push_back('{69,  st(14, 1, 0), st(14, 1, 0)});
        tbl.push_back('{70,  st(15, 1, 0), st(15, 1, 0)});
        tbl.push_back('{74,  st(15, 1, 0), st(15, 1, 0)});
        tbl.push_back('{81,  st(15, 1, 0), st(15, 1, 0)});
        tbl.push_back('{82,  st(14, 1, 0), st(14, 1, 0)});
        tbl.push_back('{90,  st(13, 1, 0), st(13, 1, 0)});
        tbl.push_back('{186, st(1, 1, 0),  st(1, 1, 0)});
        tbl.push_back('{194, st(0, 1, 0),  st(0, 1, 0)});
        tbl.push_back('{201, st(0, 1, 0),  st(0, 1, 0)});
        tbl.push_back('{202, st(0, 0, 1),  st(0, 1, 0)});
        tbl.push_back('{203, st(0, 0, 0),  st(0, 1, 0)});
        tbl.push_back('{206, st(0, 0, 0),  st(1, 1, 0)});
        tbl.push_back('{262, st(0, 0, 0),  st(15, 1, 0)});
        tbl.push_back('{393, st(0, 0, 0),  st(0, 1, 0)});
        tbl.push_back('{394, st(0, 0, 0),  st(0, 0, 1)});
        tbl.push_back('{395, st(0, 0, 0),  st(0, 0, 0)});

        clear_sched();
        go_at[0] = 10;
        go_at[1] = 30;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            run_to(tbl[i].e);
            chk("seq_l1", {led1, busy1, done1}, tbl[i].x1);
            chk("seq_l2", {led2, busy2, done2}, tbl[i].x2);
        end

        // Stop mid-UP, then go+stop together in IDLE, then a clean go
        clear_sched();
        go_at[0] = 10;
        go_at[1] = 75;
        go_at[2] = 80;
        stop_at[0] = 50;
        stop_at[1] = 75;
        do_reset();
        run_to(49);
        chk("pre_stop", {led1, busy1, done1}, st(9, 1, 0));
        run_to(50);
        chk("stop_l1", {led1, busy1, done1}, st(0, 0, 0));
        chk("stop_l2", {led2, busy2, done2}, st(0, 0, 0));
        seen = 1'b0;
        while (edge_n < 74) begin
            run_to(edge_n + 1);
            if (done1 || busy1 || done2 || busy2) seen = 1'b1;
        end
        chk("no_done_after_stop", {4'd0, 1'b0, seen}, st(0, 0, 0));
        run_to(75);
        chk("go_stop_same", {led1, busy1, done1}, st(0, 0, 0));
        run_to(80);
        chk("go_after", {led1, busy1, done1}, st(0, 1, 0));
        run_to(84);
        chk("go_after_tick", {led1, busy1, done1}, st(1, 1, 0));

        // Asynchronous reset in the middle of the down phase
        clear_sched();
        go_at[0] = 10;
        do_reset();
        run_to(140);
        chk("pre_rst", {led1, busy1, done1}, st(7, 1, 0));
        #2 rst_btn = 1'b0;
        #1;
        chk("async_rst1", {led1, busy1, done1}, st(0, 0, 0));
        chk("async_rst2", {led2, busy2, done2}, st(0, 0, 0));
        @(posedge clk);
        #1;
        rst_btn = 1'b1;
        edge_n = 0;
        clear_sched();
        drive_next();
        run_to(12);
        chk("idle_after_rst", {led1, busy1, done1}, st(0, 0, 0));

        // Pause window covering edges 20..28
        clear_sched();
        go_at[0] = 10;
        p_lo = 20;
        p_hi = 28;
        do_reset();
`ifdef SEQ_PAUSE_EN
        run_to(22);
        chk("pause_hold", {led1, busy1, done1}, st(2, 1, 0));
        run_to(30);
        chk("pause_late", {led1, busy1, done1}, st(2, 1, 0));
        run_to(31);
        chk("pause_resume", {led1, busy1, done1}, st(3, 1, 0));
        run_to(210);
        chk("pause_busy", {led1, busy1, done1}, st(0, 1, 0));
        run_to(211);
        chk("pause_done", {led1, busy1, done1}, st(0, 0, 1));
`else
        run_to(22);
        chk("pause_ignored", {led1, busy1, done1}, st(3, 1, 0));
        run_to(30);
        chk("pause_ign_30", {led1, busy1, done1}, st(5, 1, 0));
        run_to(202);
        chk("pause_ign_done", {led1, busy1, done1}, st(0, 0, 1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
